// File: rtl/result_unloader_if.sv
// Result unloader port bundle: the start/result request side plus the
// byte-wide output stream.
//
// Output handshake: a byte moves on a rising CLK edge where out_valid and
// out_ready are both 1. Once out_valid is raised, data_out/ctrl_out hold
// stable and out_valid stays high until that transfer happens (reset excepted).
// out_ready may change freely and has no combinational path to any output.
interface result_unloader_if #(
    parameter int ELEM_W    = 16,
    parameter int MAX_ELEMS = 4,
    parameter int MAT_W     = ELEM_W * MAX_ELEMS
);
    logic             start;
    logic [MAT_W-1:0] res_mat;
    logic [3:0]       rows;
    logic [3:0]       cols;
    logic             out_ready;
    logic [7:0]       data_out;
    logic [1:0]       ctrl_out;
    logic             out_valid;
    logic             busy;
    logic             done;

    // Request/consumer side (testbench or upstream logic).
    modport master (
        output start, res_mat, rows, cols, out_ready,
        input  data_out, ctrl_out, out_valid, busy, done
    );

    // Unloader side.
    modport slave (
        input  start, res_mat, rows, cols, out_ready,
        output data_out, ctrl_out, out_valid, busy, done
    );
endinterface

// File: rtl/result_unloader.sv
// result_unloader: serialises a packed result matrix into a framed byte
// stream. Frame layout: header rows/cols (ctrl 1), two bytes per element
// high byte first (ctrl 0), optional XOR checksum (ctrl 3), end marker 0x00
// (ctrl 2).
//
// Optional feature macro: CHECKSUM_EN adds the checksum byte before the end
// marker. Without it the data phase goes straight to the end marker.
//
// Every output is a register. The next byte is computed while the current one
// is presented and loaded on its transfer edge. During the one-cycle done
// pulse busy is still 1, so a start in that cycle is ignored; busy drops on
// the following edge.
module result_unloader #(
    parameter int ELEM_W    = 16,
    parameter int MAX_ELEMS = 4,
    parameter int MAT_W     = ELEM_W * MAX_ELEMS
) (
    input  logic              CLK,
    input  logic              RST,
    result_unloader_if.slave  bus,
    output logic [2:0]        o_dbg_state
);

    localparam int IDX_W = 3;

    localparam logic [1:0] CTRL_DATA = 2'd0;
    localparam logic [1:0] CTRL_HDR  = 2'd1;
    localparam logic [1:0] CTRL_END  = 2'd2;
`ifdef CHECKSUM_EN
    localparam logic [1:0] CTRL_CSUM = 2'd3;
`endif

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR  = 3'd1,
        S_DATA = 3'd2,
`ifdef CHECKSUM_EN
        S_CSUM = 3'd3,
`endif
        S_END  = 3'd4
    } state_t;

    state_t           r_state, w_state;
    logic [MAT_W-1:0] r_shadow, w_shadow;
    logic [3:0]       r_cols, w_cols;
    logic [IDX_W-1:0] r_n, w_n;
    logic [IDX_W-1:0] r_elem, w_elem;
    logic             r_phase, w_phase;
    logic             r_hdr, w_hdr;
    logic [7:0]       r_csum, w_csum;
    logic [7:0]       r_data, w_data;
    logic [1:0]       r_ctrl, w_ctrl;
    logic             r_valid, w_valid;
    logic             r_busy, w_busy;
    logic             r_done, w_done;

    logic             w_xfer;
    logic [7:0]       w_prod;
    logic [IDX_W-1:0] w_n_clamp;
    logic [7:0]       w_csum_upd;

    // Pick the high or low byte of element e; element 0 sits in the MSBs.
    function automatic logic [7:0] elem_byte(input logic [MAT_W-1:0] m,
                                             input logic [IDX_W-1:0] e,
                                             input logic hi);
        logic [MAT_W-1:0] s;
        s = m << (int'(e) * ELEM_W);
        if (hi) return s[MAT_W-1 -: 8];
        else    return s[MAT_W-ELEM_W +: 8];
    endfunction

    assign w_xfer     = r_valid && bus.out_ready;
    assign w_prod     = {4'b0, bus.rows} * {4'b0, bus.cols};
    assign w_n_clamp  = (w_prod > 8'(MAX_ELEMS)) ? IDX_W'(MAX_ELEMS) : w_prod[IDX_W-1:0];
    assign w_csum_upd = r_csum ^ r_data;

    // State and output registers; reset aborts any frame in progress.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state  <= S_IDLE;
            r_shadow <= '0;
            r_cols   <= '0;
            r_n      <= '0;
            r_elem   <= '0;
            r_phase  <= 1'b0;
            r_hdr    <= 1'b0;
            r_csum   <= '0;
            r_data   <= 8'h00;
            r_ctrl   <= CTRL_END;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_shadow <= w_shadow;
            r_cols   <= w_cols;
            r_n      <= w_n;
            r_elem   <= w_elem;
            r_phase  <= w_phase;
            r_hdr    <= w_hdr;
            r_csum   <= w_csum;
            r_data   <= w_data;
            r_ctrl   <= w_ctrl;
            r_valid  <= w_valid;
            r_busy   <= w_busy;
            r_done   <= w_done;
        end
    end

    // Next state and next presented byte; only a transfer advances the frame.
    always_comb begin
        w_state  = r_state;
        w_shadow = r_shadow;
        w_cols   = r_cols;
        w_n      = r_n;
        w_elem   = r_elem;
        w_phase  = r_phase;
        w_hdr    = r_hdr;
        w_csum   = r_csum;
        w_data   = r_data;
        w_ctrl   = r_ctrl;
        w_valid  = r_valid;
        w_busy   = r_busy;
        w_done   = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                // r_busy is still high during the done cycle.
                if (bus.start && !r_busy) begin
                    w_shadow = bus.res_mat;
                    w_cols   = bus.cols;
                    w_n      = w_n_clamp;
                    w_elem   = '0;
                    w_phase  = 1'b0;
                    w_hdr    = 1'b0;
                    w_csum   = '0;
                    w_data   = {4'b0, bus.rows};
                    w_ctrl   = CTRL_HDR;
                    w_valid  = 1'b1;
                    w_busy   = 1'b1;
                    w_state  = S_HDR;
                end
            end

            S_HDR: begin
                if (w_xfer) begin
                    if (!r_hdr) begin
                        w_hdr  = 1'b1;
                        w_data = {4'b0, r_cols};
                    end else if (r_n != '0) begin
                        w_state = S_DATA;
                        w_phase = 1'b0;
                        w_data  = elem_byte(r_shadow, r_elem, 1'b1);
                        w_ctrl  = CTRL_DATA;
                    end else begin
`ifdef CHECKSUM_EN
                        w_state = S_CSUM;
                        w_data  = r_csum;
                        w_ctrl  = CTRL_CSUM;
`else
                        w_state = S_END;
                        w_data  = 8'h00;
                        w_ctrl  = CTRL_END;
`endif
                    end
                end
            end

            S_DATA: begin
                if (w_xfer) begin
                    w_csum = w_csum_upd;
                    if (!r_phase) begin
                        w_phase = 1'b1;
                        w_data  = elem_byte(r_shadow, r_elem, 1'b0);
                    end else if (r_elem == r_n - 1'b1) begin
`ifdef CHECKSUM_EN
                        w_state = S_CSUM;
                        w_data  = w_csum_upd;
                        w_ctrl  = CTRL_CSUM;
`else
                        w_state = S_END;
                        w_data  = 8'h00;
                        w_ctrl  = CTRL_END;
`endif
                    end else begin
                        w_elem  = r_elem + 1'b1;
                        w_phase = 1'b0;
                        w_data  = elem_byte(r_shadow, r_elem + 1'b1, 1'b1);
                    end
                end
            end

`ifdef CHECKSUM_EN
            S_CSUM: begin
                if (w_xfer) begin
                    w_state = S_END;
                    w_data  = 8'h00;
                    w_ctrl  = CTRL_END;
                end
            end
`endif

            S_END: begin
                if (w_xfer) begin
                    w_state = S_IDLE;
                    w_valid = 1'b0;
                    w_done  = 1'b1;
                    w_data  = 8'h00;
                    w_ctrl  = CTRL_END;
                end
            end

            default: begin
                w_state = S_IDLE;
                w_valid = 1'b0;
                w_busy  = 1'b0;
            end
        endcase
    end

    assign bus.data_out  = r_data;
    assign bus.ctrl_out  = r_ctrl;
    assign bus.out_valid = r_valid;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_result_unloader.sv
// Bench for result_unloader: randomized frames and ready patterns checked
// against a byte-list model of the frame format.
module tb_result_unloader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int hold_err = 0;

    logic [9:0] exp_q[$];
    logic [9:0] got_q[$];

    localparam logic [63:0] MAT_A = 64'h1122334455667788;

    result_unloader_if #(.ELEM_W(16), .MAX_ELEMS(4)) bus ();

    result_unloader #(.ELEM_W(16), .MAX_ELEMS(4)) dut (
        .CLK         (clk),
        .RST         (rst),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    // Clock and reset
    always #5 clk = ~clk;

    // Reference model: the byte list of one frame, built from the frame rules.
    task automatic model_frame(input logic [63:0] m, input int r, input int c);
        int         n;
        logic [15:0] el;
        logic [7:0]  x;
        n = r * c;
        if (n > 4) n = 4;
        x = 8'h00;
        exp_q.push_back({2'd1, 8'(r)});
        exp_q.push_back({2'd1, 8'(c)});
        for (int e = 0; e < n; e++) begin
            el = 16'((m >> (16 * (3 - e))) & 64'hFFFF);
            exp_q.push_back({2'd0, el[15:8]});
            exp_q.push_back({2'd0, el[7:0]});
            x = x ^ el[15:8] ^ el[7:0];
        end
`ifdef CHECKSUM_EN
        exp_q.push_back({2'd3, x});
`endif
        exp_q.push_back({2'd2, 8'h00});
    endtask

    // Driver: one clock; inputs are set before the call, outputs read after.
    task automatic tick();
        logic       stalled;
        logic [9:0] held;
        stalled = bus.out_valid && !bus.out_ready;
        held    = {bus.ctrl_out, bus.data_out};
        if (bus.out_valid && bus.out_ready) got_q.push_back({bus.ctrl_out, bus.data_out});
        @(posedge clk);
        @(negedge clk);
        if (stalled && (!bus.out_valid || {bus.ctrl_out, bus.data_out} !== held)) hold_err++;
        if (bus.done) done_cnt++;
    endtask

    task automatic new_frame();
        exp_q.delete();
        got_q.delete();
        done_cnt = 0;
        hold_err = 0;
    endtask

    task automatic pulse_start(input logic [63:0] m, input int r, input int c);
        bus.res_mat = m;
        bus.rows    = 4'(r);
        bus.cols    = 4'(c);
        bus.start   = 1'b1;
        tick();
        bus.start   = 1'b0;
    endtask

    // Run until done; rnd randomizes out_ready each cycle.
    task automatic wait_done(input bit rnd, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (rnd) bus.out_ready = ($urandom_range(0, 3) != 0);
            tick();
            if (bus.done) begin
                ok = 1'b1;
                break;
            end
        end
        bus.out_ready = 1'b1;
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.res_mat = '0; bus.rows = '0; bus.cols = '0; bus.out_ready = 1'b1;
        rst = 1'b1;
        tick(); tick();
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.done); end
        n_checks++; if (bus.ctrl_out !== 2'd2) begin n_fail++; $display("FAIL reset_ctrl: got %0d want 2", bus.ctrl_out); end
        n_checks++; if (bus.data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", bus.data_out); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        bit ok;
        new_frame();
        model_frame(MAT_A, 2, 2);
        pulse_start(MAT_A, 2, 2);
        n_checks++; if (bus.out_valid !== 1'b1 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL basic_latency: got valid=%b busy=%b want 1 1", bus.out_valid, bus.busy); end
        wait_done(1'b0, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL basic_timeout: got no done want done"); end
        tick();
        n_checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_fail++; $display("FAIL basic_idle: got busy=%b done=%b want 0 0", bus.busy, bus.done); end
        n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL basic_done_cnt: got %0d want 1", done_cnt); end
        n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL basic_len: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL basic_byte[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_stall();
        bit ok;
        bit seen;
        new_frame();
        model_frame(MAT_A, 2, 2);
        pulse_start(MAT_A, 2, 2);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (bus.out_valid && bus.data_out === 8'h33 && bus.ctrl_out === 2'd0) seen = 1'b1;
            else tick();
        end
        n_checks++; if (!seen) begin n_fail++; $display("FAIL stall_reach: got no 33/0 want 33/0"); end
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (bus.out_valid !== 1'b1 || bus.data_out !== 8'h33 || bus.ctrl_out !== 2'd0) begin
                n_fail++; $display("FAIL stall_hold[%0d]: got v=%b %h/%0d want 1 33/0", i, bus.out_valid, bus.data_out, bus.ctrl_out);
            end
        end
        bus.out_ready = 1'b1;
        wait_done(1'b0, ok);
        n_checks++; if (!ok || hold_err !== 0) begin n_fail++; $display("FAIL stall_done: got ok=%b hold_err=%0d want 1 0", ok, hold_err); end
        n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL stall_len: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL stall_byte[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        tick();
    endtask

    task automatic test_dims();
        int rt[6] = '{1, 3, 0, 4, 2, 15};
        int ct[6] = '{3, 3, 4, 0, 1, 15};
        bit ok;
        for (int k = 0; k < 6; k++) begin
            new_frame();
            model_frame(MAT_A, rt[k], ct[k]);
            pulse_start(MAT_A, rt[k], ct[k]);
            wait_done(1'b0, ok);
            tick();
            n_checks++; if (!ok || done_cnt !== 1) begin n_fail++; $display("FAIL dims_done[%0d]: got ok=%b cnt=%0d want 1 1", k, ok, done_cnt); end
            n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL dims_len[%0d]: got %0d want %0d", k, got_q.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL dims_byte[%0d][%0d]: got %h want %h", k, i, got_q[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_ignore_start();
        bit ok;
        bit seen;
        new_frame();
        model_frame(MAT_A, 2, 2);
        pulse_start(MAT_A, 2, 2);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (bus.out_valid && bus.data_out === 8'h44 && bus.ctrl_out === 2'd0) seen = 1'b1;
            else tick();
        end
        n_checks++; if (!seen) begin n_fail++; $display("FAIL ignore_reach: got no 44/0 want 44/0"); end
        pulse_start(64'hDEADBEEFCAFEF00D, 1, 1);
        wait_done(1'b0, ok);
        tick();
        n_checks++; if (!ok || bus.busy !== 1'b0) begin n_fail++; $display("FAIL ignore_done: got ok=%b busy=%b want 1 0", ok, bus.busy); end
        n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL ignore_len: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL ignore_byte[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [63:0] m;
        new_frame();
        pulse_start(MAT_A, 1, 1);
        wait_done(1'b0, ok);
        n_checks++; if (!ok || bus.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_done_busy: got ok=%b busy=%b want 1 1", ok, bus.busy); end
        pulse_start(MAT_A, 2, 2);
        n_checks++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL b2b_ignored: got valid=%b busy=%b want 0 0", bus.out_valid, bus.busy); end
        new_frame();
        m = {$urandom, $urandom};
        model_frame(m, 2, 1);
        pulse_start(m, 2, 1);
        n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_accept: got valid=%b want 1", bus.out_valid); end
        wait_done(1'b0, ok);
        tick();
        n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL b2b_len: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_byte[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_random();
        bit ok;
        logic [63:0] m;
        int r, c;
        for (int k = 0; k < 10; k++) begin
            new_frame();
            m = {$urandom, $urandom};
            r = $urandom_range(0, 5);
            c = $urandom_range(0, 5);
            model_frame(m, r, c);
            pulse_start(m, r, c);
            wait_done(1'b1, ok);
            tick();
            n_checks++; if (!ok || done_cnt !== 1 || hold_err !== 0) begin
                n_fail++; $display("FAIL rand_ctl[%0d]: got ok=%b cnt=%0d hold_err=%0d want 1 1 0", k, ok, done_cnt, hold_err);
            end
            n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rand_len[%0d]: got %0d want %0d", k, got_q.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_byte[%0d][%0d]: got %h want %h", k, i, got_q[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_mid_reset();
        bit ok;
        bit seen;
        logic [63:0] m;
        new_frame();
        pulse_start(MAT_A, 2, 2);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (bus.out_valid && bus.data_out === 8'h33) seen = 1'b1;
            else tick();
        end
        n_checks++; if (!seen) begin n_fail++; $display("FAIL mrst_reach: got no 5th byte want 33"); end
        #1 rst = 1'b1;
        #1;
        n_checks++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.ctrl_out !== 2'd2) begin
            n_fail++; $display("FAIL mrst_async: got v=%b busy=%b ctrl=%0d want 0 0 2", bus.out_valid, bus.busy, bus.ctrl_out);
        end
        tick(); tick();
        rst = 1'b0;
        tick();
        n_checks++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL mrst_release: got v=%b busy=%b want 0 0", bus.out_valid, bus.busy); end
        new_frame();
        m = {$urandom, $urandom};
        model_frame(m, 3, 1);
        pulse_start(m, 3, 1);
        wait_done(1'b0, ok);
        tick();
        n_checks++; if (!ok || done_cnt !== 1) begin n_fail++; $display("FAIL mrst_done: got ok=%b cnt=%0d want 1 1", ok, done_cnt); end
        n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL mrst_len: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL mrst_byte[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_dims();
        test_ignore_start();
        test_back_to_back();
        test_random();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
